perceptron_score_monitor: RTL and testbench
===========================================

Name: perceptron_score_monitor

Overview:
Receive-side counterpart to the perceptron training sequencer. It accepts a stream of (prediction, expected) sfp pairs over a valid/ready handshake and scores each sample's classification. It groups samples into epochs, counts errors per epoch and decides convergence or timeout. It drives train_en back to the perceptron and flags done/converged for the board-level LED logic.

Parameters:
SAMPLES_PER_EPOCH, 4, samples per epoch (>=1)
MAX_EPOCHS, 10, epoch limit before giving up (>=1)
CONVERGE_EPOCHS, 2, consecutive error-free epochs required for convergence (>=1, <=MAX_EPOCHS)
CNT_W, 16, width of epoch and error counters

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; clears all state and begins scoring
in_valid  in  1  prediction/expected pair is valid this cycle
in_ready  out  1  monitor accepts the pair this cycle
prediction  in  $bits(sfp)  perceptron output, sfp format
expected  in  $bits(sfp)  target value, sfp format
train_en  out  1  high while scoring is in progress; drives perceptron training
mismatch  out  1  registered; 1 if the last accepted sample was misclassified
epoch_count  out  CNT_W  number of completed epochs
epoch_errors  out  CNT_W  error count of the last completed epoch
total_errors  out  CNT_W  errors since start, saturating
done  out  1  scoring finished; held until next start
converged  out  1  valid when done=1; 1 = convergence, 0 = timeout

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including in_ready, train_en, done and converged.
  - All internal counters are cleared.
- Classification:
  - pred_class = (prediction > 0) and exp_class = (expected > 0), both signed compares.
  - A sample is an error when pred_class != exp_class.
- Handshake:
  - A transfer occurs when in_valid && in_ready.
  - in_ready is a registered state decode, high only in RUN.
  - A pair presented while in_ready=0 is not consumed. The sender must hold it.
- State IDLE:
  - in_ready=0, train_en=0.
  - start moves to RUN and clears sample_idx, cur_errors, clean_streak, epoch_count, epoch_errors, total_errors, mismatch, done and converged.
- State RUN:
  - in_ready=1, train_en=1.
  - On each transfer: mismatch updates on the next edge, cur_errors increments if error, total_errors increments if error (saturates at all-ones).
  - sample_idx increments on each transfer. The transfer with sample_idx == SAMPLES_PER_EPOCH-1 wraps sample_idx to 0 and moves to EPOCH_END.
  - Without a transfer, all counters hold.
- State EPOCH_END (exactly one cycle):
  - in_ready=0, train_en=1.
  - On exit: epoch_errors <= cur_errors, cur_errors <= 0, epoch_count increments (saturating).
  - clean_streak <= (cur_errors==0) ? clean_streak+1 : 0.
  - If the new clean_streak == CONVERGE_EPOCHS: go to DONE with converged=1.
  - Else if the new epoch_count == MAX_EPOCHS: go to DONE with converged=0.
  - Else return to RUN.
  - Convergence takes priority when both conditions hit on the same epoch.
- State DONE:
  - done=1, train_en=0, in_ready=0.
  - All outputs hold until start.
- start in any state:
  - Restarts to RUN with counters cleared; this wins over a simultaneous transfer, which is dropped.
  - start asserted during an asynchronous reset is ignored.
- Latency:
  - Each accepted sample costs 1 cycle; each epoch adds 1 EPOCH_END bubble, giving SAMPLES_PER_EPOCH+1 cycles per epoch at full throughput.
  - epoch_errors and epoch_count are visible the cycle after EPOCH_END.
  - done rises the cycle after the deciding EPOCH_END.
- Reset mid-epoch: the partial epoch is discarded, with no residual counts.

Decomposition:
- FixedPoint package supplies sfp, ONE and int_to_sfp. This block adds no new fixed-point types.
- Add to FixedPoint a function sfp_class(sfp) returning bit (x > 0), shared with the LED logic.
- Add a score_state_e enum (IDLE, RUN, EPOCH_END, DONE) in a small PerceptronPkg package.
- One natural sub-module: sat_counter (parameterised width, inc/clr, saturating), instantiated for epoch_count, cur_errors and total_errors.

Test Plan:
- Reset then idle: rst_n low mid-run then high, no start → in_ready=0, train_en=0, done=0, all counters 0; in_valid=1 is not consumed.
- Immediate convergence: start, then 8 back-to-back pairs with prediction = expected class (AND truth table, ONE/0, prediction ONE for 1,1, -ONE otherwise) → epoch_count=2, epoch_errors=0, total_errors=0, done=1, converged=1 exactly 10 cycles after the first transfer.
- Timeout: start, 40 pairs each with 1 error per epoch → epoch_count=10, epoch_errors=1, total_errors=10, done=1, converged=0, train_en=0.
- Streak reset: epochs with errors 0,1,0,0 → converged=1 at epoch_count=4; clean_streak not reached at epoch 1.
- Handshake stalls: in_valid toggled randomly, plus valid held across EPOCH_END → no sample lost or double-counted; in_ready=0 exactly one cycle per epoch.
- Restart: start asserted with a transfer pending mid-epoch 3 → transfer dropped, all counters 0 next cycle, state RUN; next 8 clean samples converge normally.

Source files
------------

// File: rtl/perceptron_score_monitor_pkg.sv
// Shared packages for the perceptron score monitor.
//   FixedPoint    : signed Q8.8 "sfp" format, the ONE constant, int_to_sfp and
//                   sfp_class (the positive/non-positive decision that the
//                   monitor and the LED logic both use).
//   PerceptronPkg : score_state_e, the scoring FSM states.
// No ports; packages only.

package FixedPoint;

  localparam int SFP_W    = 16;
  localparam int SFP_FRAC = 8;

  typedef logic signed [SFP_W-1:0] sfp;

  localparam sfp ONE = sfp'(1 << SFP_FRAC);

  function automatic sfp int_to_sfp(input int v);
    return sfp'(v <<< SFP_FRAC);
  endfunction

  // Class 1 means strictly positive; zero and negatives are class 0.
  function automatic bit sfp_class(input sfp x);
    return (x > sfp'(0));
  endfunction

endpackage

package PerceptronPkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    EPOCH_END = 2'd2,
    DONE      = 2'd3
  } score_state_e;

endpackage

// File: rtl/perceptron_score_monitor_sat_counter.sv
// sat_counter: W-bit up counter with synchronous clear and saturation.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous clear, takes priority over inc
//   inc        : increment by one, holding at all-ones
//   count      : current value

module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Clear beats increment so that a restart in the same cycle as an
  // event leaves the counter at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/perceptron_score_monitor.sv
// perceptron_score_monitor: scores a stream of (prediction, expected) sfp
// pairs, groups them into epochs, and decides convergence or timeout.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : pulse, clears everything and begins scoring
//   in_valid / in_ready : sample handshake (in_ready high only in RUN)
//   prediction/expected : sfp sample pair
//   train_en            : high while scoring (RUN and EPOCH_END)
//   mismatch            : last accepted sample was misclassified
//   epoch_count         : completed epochs (saturating)
//   epoch_errors        : errors in the last completed epoch
//   total_errors        : errors since start (saturating)
//   done / converged    : finished; converged=1 convergence, 0 timeout

module perceptron_score_monitor
  import FixedPoint::*;
  import PerceptronPkg::*;
#(
  parameter int SAMPLES_PER_EPOCH = 4,
  parameter int MAX_EPOCHS        = 10,
  parameter int CONVERGE_EPOCHS   = 2,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  sfp               prediction,
  input  sfp               expected,
  output logic             train_en,
  output logic             mismatch,
  output logic [CNT_W-1:0] epoch_count,
  output logic [CNT_W-1:0] epoch_errors,
  output logic [CNT_W-1:0] total_errors,
  output logic             done,
  output logic             converged
);

  localparam int IDX_W = (SAMPLES_PER_EPOCH > 1) ? $clog2(SAMPLES_PER_EPOCH) : 1;

  score_state_e state, state_next;

  logic [IDX_W-1:0] sample_idx;
  logic [CNT_W-1:0] cur_errors;
  logic [CNT_W-1:0] clean_streak;
  logic [CNT_W-1:0] streak_next;
  logic [CNT_W-1:0] epoch_next;
  logic             accept;
  logic             sample_err;
  logic             last_sample;
  logic             epoch_end;
  logic             hit_converge;
  logic             hit_timeout;

  // A restart drops any transfer presented in the same cycle.
  assign accept      = in_valid && in_ready && !start;
  assign sample_err  = (sfp_class(prediction) != sfp_class(expected));
  assign last_sample = (sample_idx == IDX_W'(SAMPLES_PER_EPOCH - 1));
  assign epoch_end   = (state == EPOCH_END);

  // Values the epoch bookkeeping takes on leaving EPOCH_END; the exit
  // decision must look at these, not at the registers' old values.
  assign epoch_next   = (epoch_count == '1) ? epoch_count : epoch_count + 1'b1;
  assign streak_next  = (cur_errors == '0) ? clean_streak + 1'b1 : '0;
  assign hit_converge = (streak_next == CNT_W'(CONVERGE_EPOCHS));
  assign hit_timeout  = (epoch_next == CNT_W'(MAX_EPOCHS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // in_ready/train_en/done are pure decodes of the state register, so they
  // change only on clock edges.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    train_en   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
      end
      RUN: begin
        in_ready = 1'b1;
        train_en = 1'b1;
        if (accept && last_sample) begin
          state_next = EPOCH_END;
        end
      end
      EPOCH_END: begin
        train_en = 1'b1;
        if (hit_converge || hit_timeout) begin
          state_next = DONE;
        end else begin
          state_next = RUN;
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (start) begin
      state_next = RUN;
    end
  end

  // Position within the current epoch; wraps on the epoch's last sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_idx <= '0;
    end else if (start) begin
      sample_idx <= '0;
    end else if (accept) begin
      sample_idx <= last_sample ? '0 : sample_idx + 1'b1;
    end
  end

  // Per-sample result and per-epoch summary registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch     <= 1'b0;
      epoch_errors <= '0;
      clean_streak <= '0;
      converged    <= 1'b0;
    end else if (start) begin
      mismatch     <= 1'b0;
      epoch_errors <= '0;
      clean_streak <= '0;
      converged    <= 1'b0;
    end else begin
      if (accept) begin
        mismatch <= sample_err;
      end
      if (epoch_end) begin
        epoch_errors <= cur_errors;
        clean_streak <= streak_next;
        converged    <= hit_converge;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cur_errors (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start || epoch_end),
    .inc   (accept && sample_err),
    .count (cur_errors)
  );

  sat_counter #(.W(CNT_W)) u_total_errors (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .inc   (accept && sample_err),
    .count (total_errors)
  );

  sat_counter #(.W(CNT_W)) u_epoch_count (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .inc   (epoch_end),
    .count (epoch_count)
  );

endmodule

// File: tb/tb_perceptron_score_monitor.sv
// Testbench for perceptron_score_monitor. A transaction-level model keeps the
// list of accepted samples' error flags and rebuilds epoch results from it.

module tb_perceptron_score_monitor;
  import FixedPoint::*;

  localparam int SPE   = 4;
  localparam int MAXE  = 10;
  localparam int CE    = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  sfp               prediction;
  sfp               expected;
  logic             train_en;
  logic             mismatch;
  logic [CNT_W-1:0] epoch_count;
  logic [CNT_W-1:0] epoch_errors;
  logic [CNT_W-1:0] total_errors;
  logic             done;
  logic             converged;

  perceptron_score_monitor #(
    .SAMPLES_PER_EPOCH (SPE),
    .MAX_EPOCHS        (MAXE),
    .CONVERGE_EPOCHS   (CE),
    .CNT_W             (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .prediction   (prediction),
    .expected     (expected),
    .train_en     (train_en),
    .mismatch     (mismatch),
    .epoch_count  (epoch_count),
    .epoch_errors (epoch_errors),
    .total_errors (total_errors),
    .done         (done),
    .converged    (converged)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: accepted samples' error flags plus a few flags.
  int q_err[$];
  int closed;
  bit m_run, m_bubble, m_done, m_conv, m_mis;
  int m_ec, m_ee;

  typedef struct {
    sfp pred;
    sfp expv;
    bit exp_mis;
    int exp_total;
  } vec_t;

  vec_t tbl[16];
  vec_t and_tbl[4];
  bit   took;
  int   first_cyc;

  task automatic checkVal(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit isErr(input sfp p, input sfp e);
    return (int'(p) > 0) != (int'(e) > 0);
  endfunction

  function automatic bit expReady();
    return m_run && !m_bubble && !m_done;
  endfunction

  function automatic int expTotal();
    int s = 0;
    foreach (q_err[i]) s += q_err[i];
    return s;
  endfunction

  // Replays the completed epochs from the sample history.
  task automatic modelEval(output int ec, output int ee, output bit fin, output bit conv);
    int streak = 0;
    int errs;
    ec = 0; ee = 0; fin = 0; conv = 0;
    for (int ep = 0; ep < closed && !fin; ep++) begin
      errs = 0;
      for (int s = 0; s < SPE; s++) errs += q_err[ep*SPE + s];
      ec = ep + 1;
      ee = errs;
      streak = (errs == 0) ? streak + 1 : 0;
      if (streak == CE) begin
        fin = 1; conv = 1;
      end else if (ec == MAXE) begin
        fin = 1;
      end
    end
  endtask

  task automatic modelClear(input bit run);
    q_err.delete();
    closed = 0; m_run = run; m_bubble = 0; m_done = 0; m_conv = 0; m_mis = 0;
    m_ec = 0; m_ee = 0;
  endtask

  task automatic checkOutput();
    checkVal("in_ready", in_ready, expReady());
    checkVal("train_en", train_en, m_run && !m_done);
    checkVal("done", done, m_done);
    checkVal("converged", converged, m_conv);
    checkVal("mismatch", mismatch, m_mis);
    checkVal("epoch_count", epoch_count, m_ec);
    checkVal("epoch_errors", epoch_errors, m_ee);
    checkVal("total_errors", total_errors, expTotal());
  endtask

  // One clock cycle: drive inputs, advance the model, check after the edge.
  task automatic applyStimulus(input bit st, input bit v, input sfp p, input sfp e,
                               output bit tk);
    start = st; in_valid = v; prediction = p; expected = e;
    tk = 0;
    if (st) begin
      modelClear(1);
    end else if (m_bubble) begin
      m_bubble = 0;
      closed++;
      modelEval(m_ec, m_ee, m_done, m_conv);
    end else if (expReady() && v) begin
      tk = 1;
      q_err.push_back(int'(isErr(p, e)));
      m_mis = isErr(p, e);
      if (q_err.size() % SPE == 0) m_bubble = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    start = 0;
    checkOutput();
  endtask

  // Holds the pair valid until the model says it was taken (bounded).
  task automatic sendSample(input sfp p, input sfp e);
    bit tk;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, p, e, tk);
      if (tk) begin
        in_valid = 0;
        return;
      end
    end
    checks++;
    failures++;
    $display("[TB] FAIL send_timeout: got no acceptance, required acceptance within 4 cycles");
  endtask

  task automatic idle(input int n);
    bit tk;
    for (int k = 0; k < n; k++) applyStimulus(0, 0, ONE, ONE, tk);
  endtask

  function automatic sfp randVal(input bit cls);
    case ($urandom_range(0, 3))
      0: return cls ? sfp'(1) : sfp'(0);
      1: return cls ? ONE : -ONE;
      2: return cls ? sfp'($urandom_range(1, 32767)) : sfp'(-1);
      default: return cls ? int_to_sfp(3) : sfp'(-$urandom_range(1, 32768));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Streak-reset table: epochs with errors 0,1,0,0; only row 5 is wrong.
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0: begin tbl[i].pred = ONE;     tbl[i].expv = ONE;  end
        1: begin tbl[i].pred = -ONE;    tbl[i].expv = 0;    end
        2: begin tbl[i].pred = sfp'(1); tbl[i].expv = ONE;  end
        default: begin tbl[i].pred = 0; tbl[i].expv = -ONE; end
      endcase
      tbl[i].exp_mis   = 0;
      tbl[i].exp_total = (i >= 5) ? 1 : 0;
    end
    tbl[5].pred = sfp'(-1);
    tbl[5].expv = ONE;
    tbl[5].exp_mis = 1;

    // AND truth table: only (1,1) is class 1.
    for (int i = 0; i < 4; i++) begin
      and_tbl[i].pred      = (i == 3) ? ONE : -ONE;
      and_tbl[i].expv      = (i == 3) ? ONE : sfp'(0);
      and_tbl[i].exp_mis   = 0;
      and_tbl[i].exp_total = 0;
    end

    rst_n = 0; start = 0; in_valid = 0; prediction = 0; expected = 0;
    modelClear(0);
    #2;
    checkOutput();
    #10 rst_n = 1;

    // Reset mid-run, with start held during reset, then idle with valid high.
    $display("[TB] reset then idle");
    applyStimulus(1, 0, ONE, ONE, took);
    sendSample(ONE, 0);
    sendSample(ONE, 0);
    rst_n = 0;
    start = 1;
    modelClear(0);
    #2;
    checkOutput();
    @(posedge clk);
    #1;
    checkOutput();
    start = 0;
    #2 rst_n = 1;
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, ONE, 0, took);
    checkVal("idle_total", total_errors, 0);
    checkVal("idle_ready", in_ready, 0);

    // Immediate convergence and its latency.
    $display("[TB] immediate convergence");
    applyStimulus(1, 0, ONE, ONE, took);
    first_cyc = -1;
    for (int r = 0; r < 8; r++) begin
      sendSample(and_tbl[r%4].pred, and_tbl[r%4].expv);
      if (first_cyc < 0) first_cyc = cyc - 1;
      checkVal("and_mismatch", mismatch, and_tbl[r%4].exp_mis);
    end
    for (int k = 0; k < 5 && !done; k++) idle(1);
    checkVal("conv_latency", done ? cyc - first_cyc : -1, 10);
    checkVal("conv_epochs", epoch_count, 2);
    checkVal("conv_flag", converged, 1);
    checkVal("conv_total", total_errors, 0);

    // Timeout: one error in every epoch.
    $display("[TB] timeout");
    applyStimulus(1, 0, ONE, ONE, took);
    for (int i = 0; i < 40; i++) begin
      if (i % SPE == 0) sendSample(ONE, 0);
      else sendSample(ONE, ONE);
    end
    idle(1);
    checkVal("to_epochs", epoch_count, 10);
    checkVal("to_epoch_errors", epoch_errors, 1);
    checkVal("to_total", total_errors, 10);
    checkVal("to_done", done, 1);
    checkVal("to_converged", converged, 0);
    checkVal("to_train_en", train_en, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, ONE, 0, took);
    checkVal("to_hold_total", total_errors, 10);

    // Streak reset, table-driven.
    $display("[TB] streak reset");
    applyStimulus(1, 0, ONE, ONE, took);
    for (int i = 0; i < 16; i++) begin
      sendSample(tbl[i].pred, tbl[i].expv);
      checkVal("tbl_mismatch", mismatch, tbl[i].exp_mis);
      checkVal("tbl_total", total_errors, tbl[i].exp_total);
      if (i == 4) begin
        checkVal("tbl_ep1_count", epoch_count, 1);
        checkVal("tbl_ep1_done", done, 0);
      end
    end
    idle(1);
    checkVal("streak_epochs", epoch_count, 4);
    checkVal("streak_conv", converged, 1);
    checkVal("streak_done", done, 1);

    // Restart with a transfer pending in epoch 3.
    $display("[TB] restart");
    applyStimulus(1, 0, ONE, ONE, took);
    for (int i = 0; i < 2*SPE + 2; i++) begin
      if (i % SPE == 0 && i < 2*SPE) sendSample(ONE, 0);
      else sendSample(ONE, ONE);
    end
    idle(1);
    applyStimulus(1, 1, ONE, 0, took);
    checkVal("rs_total", total_errors, 0);
    checkVal("rs_epochs", epoch_count, 0);
    checkVal("rs_mismatch", mismatch, 0);
    checkVal("rs_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) sendSample(ONE, ONE);
    idle(1);
    checkVal("rs_conv", converged, 1);
    checkVal("rs_epochs_end", epoch_count, 2);

    // Random stalls and data against the model.
    $display("[TB] random stalls");
    for (int run = 0; run < 4; run++) begin
      applyStimulus(1, 0, ONE, ONE, took);
      for (int k = 0; k < 400 && !m_done; k++) begin
        bit c = $urandom_range(0, 1);
        bit bad = ($urandom_range(0, 9) == 0);
        applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                      randVal(c), randVal(c ^ bad), took);
      end
      checkVal("rand_done", done, 1);
      for (int k = 0; k < 3; k++) applyStimulus(0, 1, ONE, 0, took);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
